// File: rtl/vector_mul_resolve.sv
// Lane-segmented carry-propagate add and half-select packing behind the vector multiplier.
// Define VMUL_RESOLVE_SINGLE_STAGE_EN to collapse the two-stage pipeline into one stage.
module vector_mul_resolve #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [63:0]      inSum,
    input  logic [63:0]      inCarry,
    input  logic [2:0]       inSew,
    input  logic             inHigh,
    input  logic [TAG_W-1:0] inTag,
    output logic             outValid,
    input  logic             outReady,
    output logic [31:0]      outResult,
    output logic [TAG_W-1:0] outTag
);

    typedef enum logic [1:0] {
        W8  = 2'd0,
        W16 = 2'd1,
        W32 = 2'd2
    } width_t;

    function automatic width_t decode_width(input logic [2:0] sew);
        width_t w;
        casez (sew)
            3'b1??:  w = W32;
            3'b01?:  w = W16;
            default: w = W8;
        endcase
        return w;
    endfunction

    // 32-bit add built from two 16-bit halves; kill_mid breaks the carry at the half boundary.
    function automatic logic [31:0] add_seg(
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic        cin,
        input  logic        kill_mid,
        output logic        cout
    );
        logic [16:0] lo;
        logic [16:0] hi;
        lo   = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, cin};
        hi   = {1'b0, a[31:16]} + {1'b0, b[31:16]} + {16'd0, lo[16] & ~kill_mid};
        cout = hi[16];
        return {hi[15:0], lo[15:0]};
    endfunction

    function automatic logic [31:0] pack_halves(
        input logic [63:0] p,
        input width_t      w,
        input logic        high
    );
        logic [31:0] r;
        r = '0;
        case (w)
            W32: r = high ? p[63:32] : p[31:0];
            W16: r = high ? {p[63:48], p[31:16]} : {p[47:32], p[15:0]};
            default: begin
                for (int unsigned i = 0; i < 4; i++) begin
                    r[8*i +: 8] = high ? p[16*i+8 +: 8] : p[16*i +: 8];
                end
            end
        endcase
        return r;
    endfunction

    width_t in_w;
    always_comb begin
        in_w = decode_width(inSew);
    end

    logic             s2_v;
    logic             s2_adv;
    logic             s2_take;
    logic [31:0]      s2_in_result;
    logic [TAG_W-1:0] s2_in_tag;

    assign s2_adv   = !s2_v || outReady;
    assign outValid = s2_v;

`ifdef VMUL_RESOLVE_SINGLE_STAGE_EN

    logic [31:0] lo_sum;
    logic [31:0] hi_sum;
    logic        mid_carry;
    logic        top_carry_unused;

    assign inReady = s2_adv;

    always_comb begin
        lo_sum       = add_seg(inSum[31:0], inCarry[31:0], 1'b0, in_w == W8, mid_carry);
        hi_sum       = add_seg(inSum[63:32], inCarry[63:32], mid_carry & (in_w == W32),
                               in_w == W8, top_carry_unused);
        s2_take      = inValid;
        s2_in_result = pack_halves({hi_sum, lo_sum}, in_w, inHigh);
        s2_in_tag    = inTag;
    end

`else

    logic             s1_v;
    logic             s1_adv;
    logic [31:0]      s1_lo;
    logic             s1_c32;
    logic [31:0]      s1_sum_hi;
    logic [31:0]      s1_carry_hi;
    width_t           s1_w;
    logic             s1_high;
    logic [TAG_W-1:0] s1_tag;

    logic [31:0]      lo_sum;
    logic             lo_cout;
    logic [31:0]      hi_sum;
    logic             hi_carry_unused;

    assign s1_adv  = !s1_v || s2_adv;
    assign inReady = s1_adv;

    always_comb begin
        lo_sum = add_seg(inSum[31:0], inCarry[31:0], 1'b0, in_w == W8, lo_cout);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_v        <= 1'b0;
            s1_lo       <= '0;
            s1_c32      <= 1'b0;
            s1_sum_hi   <= '0;
            s1_carry_hi <= '0;
            s1_w        <= W8;
            s1_high     <= 1'b0;
            s1_tag      <= '0;
        end else if (s1_adv) begin
            s1_v <= inValid;
            if (inValid) begin
                s1_lo       <= lo_sum;
                // Only a 64-bit lane lets the low word's carry reach bit 32.
                s1_c32      <= lo_cout & (in_w == W32);
                s1_sum_hi   <= inSum[63:32];
                s1_carry_hi <= inCarry[63:32];
                s1_w        <= in_w;
                s1_high     <= inHigh;
                s1_tag      <= inTag;
            end
        end
    end

    always_comb begin
        hi_sum       = add_seg(s1_sum_hi, s1_carry_hi, s1_c32, s1_w == W8, hi_carry_unused);
        s2_take      = s1_v;
        s2_in_result = pack_halves({hi_sum, s1_lo}, s1_w, s1_high);
        s2_in_tag    = s1_tag;
    end

`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_v      <= 1'b0;
            outResult <= '0;
            outTag    <= '0;
        end else if (s2_adv) begin
            s2_v <= s2_take;
            if (s2_take) begin
                outResult <= s2_in_result;
                outTag    <= s2_in_tag;
            end
        end
    end

endmodule

// File: tb/tb_vector_mul_resolve.sv
// Self-checking bench for vector_mul_resolve: directed vectors, random beats against a
// lane-arithmetic reference model, backpressure streaming and mid-operation reset.
`timescale 1ns/1ps
module tb_vector_mul_resolve;

    localparam int TAG_W = 5;
`ifdef VMUL_RESOLVE_SINGLE_STAGE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             inValid = 1'b0;
    logic             inReady;
    logic [63:0]      inSum = '0;
    logic [63:0]      inCarry = '0;
    logic [2:0]       inSew = '0;
    logic             inHigh = 1'b0;
    logic [TAG_W-1:0] inTag = '0;
    logic             outValid;
    logic             outReady = 1'b0;
    logic [31:0]      outResult;
    logic [TAG_W-1:0] outTag;

    int checks = 0;
    int errors = 0;

    vector_mul_resolve #(.TAG_W(TAG_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .inValid  (inValid),
        .inReady  (inReady),
        .inSum    (inSum),
        .inCarry  (inCarry),
        .inSew    (inSew),
        .inHigh   (inHigh),
        .inTag    (inTag),
        .outValid (outValid),
        .outReady (outReady),
        .outResult(outResult),
        .outTag   (outTag)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Each product lane is (sum + carry) mod 2^lane_width; keep the selected half of each.
    function automatic logic [31:0] model(input logic [63:0] s, input logic [63:0] c,
                                          input logic [2:0] sew, input logic h);
        int unsigned lw;
        logic [63:0] mask;
        logic [63:0] hmask;
        logic [63:0] lane;
        logic [63:0] half;
        logic [63:0] r;
        lw    = sew[2] ? 64 : (sew[1] ? 32 : 16);
        mask  = (lw == 64) ? '1 : ((64'd1 << lw) - 64'd1);
        hmask = (64'd1 << (lw / 2)) - 64'd1;
        r     = '0;
        for (int unsigned i = 0; i < 64 / lw; i++) begin
            lane = (((s >> (i * lw)) & mask) + ((c >> (i * lw)) & mask)) & mask;
            half = (h ? (lane >> (lw / 2)) : lane) & hmask;
            r    = r | (half << (i * lw / 2));
        end
        return r[31:0];
    endfunction

    task automatic run_one(input string name, input logic [63:0] s, input logic [63:0] c,
                           input logic [2:0] sew, input logic h, input logic [TAG_W-1:0] t,
                           input logic [31:0] exp);
        @(negedge clock);
        outReady = 1'b1;
        inValid  = 1'b1;
        inSum    = s;
        inCarry  = c;
        inSew    = sew;
        inHigh   = h;
        inTag    = t;
        #1;
        check({name, "_ready"}, inReady, 1'b1);
        @(negedge clock);
        inValid = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            check({name, "_early"}, outValid, 1'b0);
            @(negedge clock);
        end
        check({name, "_valid"}, outValid, 1'b1);
        check({name, "_result"}, outResult, exp);
        check({name, "_tag"}, outTag, t);
    endtask

    logic [TAG_W-1:0] q_tag[$];
    logic [31:0]      q_res[$];
    logic [63:0]      rs;
    logic [63:0]      rc;
    logic [2:0]       rsew;
    logic             rh;
    logic [TAG_W-1:0] exp_tag;
    logic [31:0]      exp_res;
    int               sent;
    int               got;
    int               occ;

    initial begin
        // Reset state
        @(negedge clock);
        #1;
        check("rst_out_valid", outValid, 1'b0);
        check("rst_out_result", outResult, 32'd0);
        check("rst_out_tag", outTag, '0);
        check("rst_in_ready", inReady, 1'b1);
        reset = 1'b0;

        // Directed vectors
        run_one("d32_lo", 64'hFFFF_FFFE_0000_0000, 64'h1, 3'b100, 1'b0, 5'd1, 32'h0000_0001);
        run_one("d32_hi", 64'hFFFF_FFFE_0000_0000, 64'h1, 3'b100, 1'b1, 5'd2, 32'hFFFF_FFFE);
        run_one("d32_c16", 64'h0000_0000_0000_FFFF, 64'h1, 3'b100, 1'b0, 5'd3, 32'h0001_0000);
        run_one("d8_kill16", 64'h0000_0000_0000_FFFF, 64'h1, 3'b001, 1'b0, 5'd4, 32'h0000_0000);
        run_one("d16_kill32", 64'h0000_0000_FFFF_FFFF, 64'h1, 3'b010, 1'b1, 5'd5, 32'h0000_0000);
        run_one("d8_lo", 64'h1234_0056_00AB_00FF, 64'h0, 3'b001, 1'b0, 5'd6, 32'h3456_ABFF);
        run_one("d8_hi", 64'h1234_0056_00AB_00FF, 64'h0, 3'b001, 1'b1, 5'd7, 32'h1200_0000);
        run_one("d0_as8", 64'h1234_0056_00AB_00FF, 64'h0, 3'b000, 1'b0, 5'd8, 32'h3456_ABFF);
        run_one("d32_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b111, 1'b0, 5'd9, 32'h0000_0000);

        // Random single beats
        for (int n = 0; n < 16; n++) begin
            rs   = {$urandom, $urandom};
            rc   = {$urandom, $urandom};
            rsew = 3'($urandom_range(0, 7));
            rh   = 1'($urandom_range(0, 1));
            run_one("rand", rs, rc, rsew, rh, TAG_W'(n), model(rs, rc, rsew, rh));
        end

        // Backpressure stream, tags 1..6, outReady pattern 1,0,0,1
        sent = 0;
        got  = 0;
        occ  = 0;
        rs   = {$urandom, $urandom};
        rc   = {$urandom, $urandom};
        rsew = 3'($urandom_range(0, 7));
        rh   = 1'($urandom_range(0, 1));
        @(negedge clock);
        for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
            outReady = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            inValid  = (sent < 6);
            inSum    = rs;
            inCarry  = rc;
            inSew    = rsew;
            inHigh   = rh;
            inTag    = TAG_W'(sent + 1);
            #1;
            check("bp_in_ready", inReady, !((occ == LAT) && !outReady));
            if (outValid && outReady) begin
                check("bp_nonempty", q_tag.size() != 0, 1'b1);
                if (q_tag.size() != 0) begin
                    exp_tag = q_tag.pop_front();
                    exp_res = q_res.pop_front();
                    check("bp_tag", outTag, exp_tag);
                    check("bp_result", outResult, exp_res);
                end
                got++;
                occ--;
            end
            if (inValid && inReady) begin
                q_tag.push_back(TAG_W'(sent + 1));
                q_res.push_back(model(rs, rc, rsew, rh));
                sent++;
                occ++;
                rs   = {$urandom, $urandom};
                rc   = {$urandom, $urandom};
                rsew = 3'($urandom_range(0, 7));
                rh   = 1'($urandom_range(0, 1));
            end
            @(negedge clock);
        end
        check("bp_received", got, 6);
        check("bp_queue_empty", q_tag.size(), 0);
        inValid  = 1'b0;
        outReady = 1'b1;

        // Reset with beats in flight
        @(negedge clock);
        outReady = 1'b0;
        inValid  = 1'b1;
        inSum    = 64'h0000_0001_0000_0001;
        inCarry  = 64'h0;
        inSew    = 3'b100;
        inTag    = 5'd20;
        @(negedge clock);
        inTag    = 5'd21;
        @(negedge clock);
        inValid  = 1'b0;
        check("rst_pre_valid", outValid, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_mid_valid", outValid, 1'b0);
        check("rst_mid_result", outResult, 32'd0);
        check("rst_mid_tag", outTag, '0);
        check("rst_mid_ready", inReady, 1'b1);
        @(negedge clock);
        reset    = 1'b0;
        outReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("rst_no_stale", outValid, 1'b0);
        end
        rs   = {$urandom, $urandom};
        rc   = {$urandom, $urandom};
        run_one("post_rst", rs, rc, 3'b010, 1'b1, 5'd30, model(rs, rc, 3'b010, 1'b1));
        @(negedge clock);
        check("post_rst_drain", outValid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
